kernel_sum_accumulator: RTL and testbench

//  Consumer end of the ternary adder-tree datapath. Tracks issued tree inputs through the fixed tree latency.

---
 rtl/kernel_sum_accumulator_pkg.sv | 16 +
 rtl/kernel_sum_accumulator_fifo.sv | 88 ++++++++
 rtl/kernel_sum_accumulator.sv | 153 +++++++++++++++
 tb/tb_kernel_sum_accumulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_sum_accumulator_pkg.sv
// Shared defaults and FSM encoding for the kernel-sum accumulator slice.
package kernel_sum_accumulator_pkg;

  localparam int unsigned TN_DEF            = 4;
  localparam int unsigned FEATURE_WIDTH_DEF = 16;
  localparam int unsigned ACC_GUARD_BITS    = 8;
  localparam int unsigned TREE_LATENCY_DEF  = 4;
  localparam int unsigned CNT_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/kernel_sum_accumulator_fifo.sv
// Two-entry first-word-fall-through result buffer with registered head and
// simultaneous push/pop; a push into a full buffer without a pop is dropped.
module result_fifo2 #(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drop_c,
  output logic             empty_next_c
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             pop_c;

  assign pop_c        = valid_q && out_ready;
  assign out_valid    = valid_q;
  assign out_data     = head_q;
  assign empty_next_c = (cnt_d == 2'd0);

  // Head register is forced to zero whenever the buffer becomes empty.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    drop_c = 1'b0;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = din;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_c) begin
            head_d = din;
          end else if (push) begin
            tail_d = din;
            cnt_d  = 2'd2;
          end else if (pop_c) begin
            head_d = '0;
            cnt_d  = 2'd0;
          end
        end
        default: begin
          if (push && pop_c) begin
            head_d = tail_q;
            tail_d = din;
          end else if (pop_c) begin
            head_d = tail_q;
            tail_d = '0;
            cnt_d  = 2'd1;
          end else if (push) begin
            drop_c = 1'b1;
          end
        end
      endcase
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/kernel_sum_accumulator.sv
// Consumer end of the adder tree: tracks issued inputs through the tree
// latency, accumulates Tn saturating partial sums and buffers the results.
module kernel_sum_accumulator
  import kernel_sum_accumulator_pkg::*;
#(
  parameter int unsigned Tn            = TN_DEF,
  parameter int unsigned FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH     = FEATURE_WIDTH + ACC_GUARD_BITS,
  parameter int unsigned TREE_LATENCY  = TREE_LATENCY_DEF,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                        fast_clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        cfg_tiles,
  input  logic [CNT_WIDTH-1:0]        cfg_outputs,
  input  logic                        issue_valid,
  input  logic [Tn*FEATURE_WIDTH-1:0] kernel_sum_tn,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Tn*ACC_WIDTH-1:0]     out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag,
  output logic                        ovf_flag
);

  localparam int unsigned OUT_W = Tn * ACC_WIDTH;
  localparam int unsigned FW    = FEATURE_WIDTH;

  state_e                  state_q, state_d;
  logic [TREE_LATENCY-1:0] dl_q, dl_d;
  logic [CNT_WIDTH-1:0]    tiles_q, tiles_d, outputs_q, outputs_d;
  logic [CNT_WIDTH-1:0]    tile_cnt_q, tile_cnt_d, out_cnt_q, out_cnt_d;
  logic [OUT_W-1:0]        acc_q, acc_d, acc_sum_c;
  logic [Tn-1:0]           sat_c;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    sat_q, sat_d, ovf_q, ovf_d;
  logic                    sum_v_c, last_tile_c, last_out_c, push_c;
  logic                    drop_c, fifo_empty_next_c;

  assign sum_v_c     = dl_q[TREE_LATENCY-1] && (state_q == ST_RUN);
  assign last_tile_c = (tile_cnt_q == tiles_q - CNT_WIDTH'(1));
  assign last_out_c  = (out_cnt_q == outputs_q - CNT_WIDTH'(1));
  assign push_c      = sum_v_c && last_tile_c && !start;

  // One saturating adder per output channel; one guard bit detects overflow.
  for (genvar i = 0; i < Tn; i++) begin : g_acc
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [FW-1:0]        ks_i;
    logic signed [ACC_WIDTH:0]   sum_i;

    assign acc_i    = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
    assign ks_i     = kernel_sum_tn[i*FW +: FW];
    assign sum_i    = (ACC_WIDTH+1)'(acc_i) + (ACC_WIDTH+1)'(ks_i);
    assign sat_c[i] = sum_i[ACC_WIDTH] ^ sum_i[ACC_WIDTH-1];
    assign acc_sum_c[i*ACC_WIDTH +: ACC_WIDTH] =
      !sat_c[i]        ? sum_i[ACC_WIDTH-1:0] :
      sum_i[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                         {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d    = state_q;
    dl_d       = (dl_q << 1) | TREE_LATENCY'(issue_valid && (state_q == ST_RUN));
    tiles_d    = tiles_q;
    outputs_d  = outputs_q;
    tile_cnt_d = tile_cnt_q;
    out_cnt_d  = out_cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    if (start) begin
      state_d    = ST_RUN;
      dl_d       = '0;
      tiles_d    = (cfg_tiles == '0) ? CNT_WIDTH'(1) : cfg_tiles;
      outputs_d  = (cfg_outputs == '0) ? CNT_WIDTH'(1) : cfg_outputs;
      tile_cnt_d = '0;
      out_cnt_d  = '0;
      acc_d      = '0;
      sat_d      = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      ovf_d = ovf_q | drop_c;
      if (sum_v_c) begin
        sat_d = sat_q | (|sat_c);
        if (last_tile_c) begin
          acc_d      = '0;
          tile_cnt_d = '0;
          out_cnt_d  = out_cnt_q + CNT_WIDTH'(1);
          if (last_out_c) state_d = ST_DRAIN;
        end else begin
          acc_d      = acc_sum_c;
          tile_cnt_d = tile_cnt_q + CNT_WIDTH'(1);
        end
      end
      // Leave DRAIN on the edge that empties the buffer.
      if (state_q == ST_DRAIN && fifo_empty_next_c) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dl_q       <= '0;
      tiles_q    <= '0;
      outputs_q  <= '0;
      tile_cnt_q <= '0;
      out_cnt_q  <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      tiles_q    <= tiles_d;
      outputs_q  <= outputs_d;
      tile_cnt_q <= tile_cnt_d;
      out_cnt_q  <= out_cnt_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;

  result_fifo2 #(.WIDTH(OUT_W)) u_fifo (
    .clk          (fast_clk),
    .rst_n        (rst_n),
    .clr          (start),
    .push         (push_c),
    .din          (acc_sum_c),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .drop_c       (drop_c),
    .empty_next_c (fifo_empty_next_c)
  );

endmodule

// File: tb/tb_kernel_sum_accumulator.sv
// Directed bench for kernel_sum_accumulator: table of single-result cases
// plus hand-written sequences for buffering, saturation, restart and reset.
module tb_kernel_sum_accumulator;

  localparam int unsigned TN  = 4;
  localparam int unsigned FW  = 16;
  localparam int unsigned AW  = 24;
  localparam int unsigned TL  = 4;
  localparam int unsigned CW  = 16;

  logic               fast_clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [CW-1:0]      cfg_tiles, cfg_outputs;
  logic               issue_valid;
  logic [TN*FW-1:0]   kernel_sum_tn;
  logic               out_valid, out_ready;
  logic [TN*AW-1:0]   out_data;
  logic               busy, done, sat_flag, ovf_flag;

  logic [TN*FW-1:0]   ks_issue;
  logic [TN*FW-1:0]   ks_line [TL];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  kernel_sum_accumulator #(
    .Tn(TN), .FEATURE_WIDTH(FW), .ACC_WIDTH(AW), .TREE_LATENCY(TL), .CNT_WIDTH(CW)
  ) dut (
    .fast_clk      (fast_clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_tiles     (cfg_tiles),
    .cfg_outputs   (cfg_outputs),
    .issue_valid   (issue_valid),
    .kernel_sum_tn (kernel_sum_tn),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .sat_flag      (sat_flag),
    .ovf_flag      (ovf_flag)
  );

  always #5 fast_clk = ~fast_clk;

  // Stand-in for the adder tree: issued operands reappear TL cycles later.
  always @(posedge fast_clk) begin
    ks_line[0] <= ks_issue;
    for (int i = 1; i < TL; i++) ks_line[i] <= ks_line[i-1];
  end
  assign kernel_sum_tn = ks_line[TL-1];

  typedef struct {
    logic [CW-1:0]    tiles;
    int               n;
    logic [TN*FW-1:0] ks;
    logic [TN*AW-1:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge fast_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [TN*AW-1:0] act, input logic [TN*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_start(input logic [CW-1:0] tiles, input logic [CW-1:0] outs);
    start = 1'b1; cfg_tiles = tiles; cfg_outputs = outs;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      fails++;
      $display("FAIL %s: out_valid timeout after %0d cycles", name, max);
    end
  endtask

  function automatic logic [TN*FW-1:0] mk_ks(input int a);
    logic [FW-1:0] v;
    v = a[FW-1:0];
    return {TN{v}};
  endfunction

  function automatic logic [TN*AW-1:0] mk_acc(input int a);
    logic [AW-1:0] v;
    v = a[AW-1:0];
    return {TN{v}};
  endfunction

  initial begin
    int first;
    vecs[0] = '{16'd3, 3, {16'hFFFC, 16'h0003, 16'h0002, 16'h0001},
                {24'hFFFFF4, 24'h000009, 24'h000006, 24'h000003}};
    vecs[1] = '{16'd0, 1, {16'h8000, 16'h0064, 16'h0000, 16'hFFFF},
                {24'hFF8000, 24'h000064, 24'h000000, 24'hFFFFFF}};
    vecs[2] = '{16'd2, 2, {16'hFFF9, 16'h0005, 16'h8000, 16'h7FFF},
                {24'hFFFFF2, 24'h00000A, 24'hFF0000, 24'h00FFFE}};
    vecs[3] = '{16'd5, 5, {16'h0001, 16'h0000, 16'hFFFD, 16'h000A},
                {24'h000005, 24'h000000, 24'hFFFFF1, 24'h000032}};

    rst_n = 1'b0; start = 1'b0; cfg_tiles = '0; cfg_outputs = '0;
    issue_valid = 1'b0; out_ready = 1'b0; ks_issue = '0;
    tick(); tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flags", {sat_flag, ovf_flag}, 0);
    #2 rst_n = 1'b1;
    tick();

    // Single-result table cases, out_ready held high.
    foreach (vecs[v]) begin
      out_ready = 1'b1;
      do_start(vecs[v].tiles, 16'd1);
      first = cyc;
      for (int k = 0; k < vecs[v].n; k++) begin
        issue_valid = 1'b1; ks_issue = vecs[v].ks;
        tick();
      end
      issue_valid = 1'b0;
      wait_valid($sformatf("vec%0d_valid", v), 20);
      chk($sformatf("vec%0d_latency", v), cyc - first, vecs[v].n + TL);
      chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp);
      chk($sformatf("vec%0d_busy", v), busy, 1);
      tick();
      chk($sformatf("vec%0d_done", v), {done, out_valid, out_data != 0}, 3'b100);
      tick();
      chk($sformatf("vec%0d_idle", v), {done, busy, sat_flag, ovf_flag}, 0);
    end

    // Two buffered, two dropped with downstream stalled.
    out_ready = 1'b0;
    do_start(16'd1, 16'd4);
    for (int k = 1; k <= 4; k++) begin
      issue_valid = 1'b1; ks_issue = mk_ks(k);
      tick();
    end
    issue_valid = 1'b0;
    repeat (6) tick();
    chk("stall_head", out_data, mk_acc(1));
    chk("stall_state", {out_valid, busy, ovf_flag, done}, 4'b1110);
    out_ready = 1'b1;
    tick();
    chk("stall_second", {out_valid, out_data}, {1'b1, mk_acc(2)});
    tick();
    chk("stall_done", {out_valid, done, busy, out_data != 0}, 4'b0100);

    // Full buffer with a pop in the push cycle: nothing dropped.
    out_ready = 1'b0;
    do_start(16'd1, 16'd3);
    for (int k = 1; k <= 3; k++) begin
      issue_valid = 1'b1; ks_issue = mk_ks(10 * k);
      tick();
    end
    issue_valid = 1'b0;
    repeat (3) tick();
    chk("full_head", {out_valid, out_data}, {1'b1, mk_acc(10)});
    out_ready = 1'b1;
    tick();
    chk("full_r2", out_data, mk_acc(20));
    tick();
    chk("full_r3", out_data, mk_acc(30));
    tick();
    chk("full_end", {out_valid, done, ovf_flag}, 3'b010);

    // Saturation on channel 0 over 300 tiles.
    do_start(16'd300, 16'd1);
    issue_valid = 1'b1; ks_issue = {16'd100, 16'hFFFF, 16'h0001, 16'h7FFF};
    repeat (300) tick();
    issue_valid = 1'b0;
    wait_valid("sat_valid", 20);
    chk("sat_data", out_data, {24'h007530, 24'hFFFED4, 24'h00012C, 24'h7FFFFF});
    chk("sat_flags", {sat_flag, ovf_flag}, 2'b10);
    tick(); tick();

    // Restart while a sum is still inside the tree.
    do_start(16'd2, 16'd1);
    issue_valid = 1'b1; ks_issue = mk_ks(100);
    tick();
    issue_valid = 1'b0;
    tick();
    do_start(16'd2, 16'd1);
    chk("restart_clear", {out_valid, sat_flag, ovf_flag, busy}, 4'b0001);
    for (int k = 0; k < 2; k++) begin
      issue_valid = 1'b1; ks_issue = mk_ks(7);
      tick();
    end
    issue_valid = 1'b0;
    wait_valid("restart_valid", 20);
    chk("restart_data", out_data, mk_acc(14));
    tick(); tick();

    // Asynchronous reset between edges, then issues while IDLE.
    out_ready = 1'b0;
    do_start(16'd1, 16'd4);
    for (int k = 1; k <= 3; k++) begin
      issue_valid = 1'b1; ks_issue = mk_ks(k);
      tick();
    end
    issue_valid = 1'b0;
    repeat (6) tick();
    chk("pre_reset", {out_valid, busy, ovf_flag}, 3'b111);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, busy, done, sat_flag, ovf_flag, out_data != 0}, 0);
    #1 rst_n = 1'b1;
    issue_valid = 1'b1; ks_issue = mk_ks(55);
    repeat (8) tick();
    issue_valid = 1'b0;
    chk("idle_issue", {out_valid, busy, out_data != 0}, 0);
    out_ready = 1'b1;
    do_start(16'd1, 16'd1);
    issue_valid = 1'b1; ks_issue = mk_ks(-9);
    tick();
    issue_valid = 1'b0;
    wait_valid("post_reset_valid", 20);
    chk("post_reset_data", out_data, mk_acc(-9));
    tick();
    chk("post_reset_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
